// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - round-robin writeback port arbiter with register busy scoreboard
// Stalls decode on RAW/WAW hazards until the pending write has reached the register file.
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rs,
  input  logic [AW-1:0] issue_rt,
  input  logic          rs_used,
  input  logic          rt_used,
  input  logic [AW-1:0] issue_rd,
  input  logic          rd_wr,
  output logic          issue_stall,
  input  logic          alu_wb_req,
  input  logic [AW-1:0] alu_wb_addr,
  input  logic [DW-1:0] alu_wb_data,
  input  logic          mem_wb_req,
  input  logic [AW-1:0] mem_wb_addr,
  input  logic [DW-1:0] mem_wb_data,
  output logic          alu_wb_gnt,
  output logic          mem_wb_gnt,
  output logic          rf_wr,
  output logic [AW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_wr_data,
  output logic [5:0]    busy_count,
  output logic          wb_err
);

  typedef enum logic {PRI_MEM = 1'b0, PRI_ALU = 1'b1} pri_t;

  pri_t            pri_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [5:0]      count_d;
  logic            any_gnt;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            issue_ok;
  logic            wb_err_set;

  // Grants are suppressed while reset is held so no write is accepted mid-reset.
  always_comb begin
    alu_wb_gnt = 1'b0;
    mem_wb_gnt = 1'b0;
    if (reset) begin
      if (alu_wb_req && mem_wb_req) begin
        alu_wb_gnt = (pri_q == PRI_ALU);
        mem_wb_gnt = (pri_q == PRI_MEM);
      end else begin
        alu_wb_gnt = alu_wb_req;
        mem_wb_gnt = mem_wb_req;
      end
    end
  end

  always_comb begin
    any_gnt  = alu_wb_gnt | mem_wb_gnt;
    win_addr = alu_wb_gnt ? alu_wb_addr : mem_wb_addr;
    win_data = alu_wb_gnt ? alu_wb_data : mem_wb_data;
  end

  always_comb begin
    issue_stall = reset & issue_valid &
                  ((rs_used & busy_q[issue_rs]) |
                   (rt_used & busy_q[issue_rt]) |
                   (rd_wr   & busy_q[issue_rd]));
    issue_ok    = issue_valid & ~issue_stall;
    wb_err_set  = any_gnt & (win_addr != '0) & ~busy_q[win_addr];
  end

  // Clear from the completing write first, then the new issue's set, so set wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_wr)
      busy_d[rf_wr_addr] = 1'b0;
    if (issue_ok && rd_wr && (issue_rd != '0))
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NREG; i++)
      count_d = count_d + 6'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pri_q      <= PRI_MEM;
      busy_q     <= '0;
      busy_count <= '0;
      rf_wr      <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      wb_err     <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_count <= count_d;
      rf_wr      <= any_gnt & (win_addr != '0);
      if (any_gnt) begin
        rf_wr_addr <= win_addr;
        rf_wr_data <= win_data;
      end
      if (wb_err_set)
        wb_err <= 1'b1;
      // Pointer always moves away from whoever just won.
      if (alu_wb_gnt)
        pri_q <= PRI_MEM;
      else if (mem_wb_gnt)
        pri_q <= PRI_ALU;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard bench for regfile_scoreboard
// Expected register-file writes are queued by the stimulus and checked by a separate monitor.
`timescale 1ns/1ps
module tb_regfile_scoreboard;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          issue_valid, rs_used, rt_used, rd_wr;
  logic [AW-1:0] issue_rs, issue_rt, issue_rd;
  logic          issue_stall;
  logic          alu_wb_req, mem_wb_req;
  logic [AW-1:0] alu_wb_addr, mem_wb_addr;
  logic [DW-1:0] alu_wb_data, mem_wb_data;
  logic          alu_wb_gnt, mem_wb_gnt;
  logic          rf_wr;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic [5:0]    busy_count;
  logic          wb_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .rs_used(rs_used), .rt_used(rt_used), .issue_rd(issue_rd), .rd_wr(rd_wr),
    .issue_stall(issue_stall),
    .alu_wb_req(alu_wb_req), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .mem_wb_req(mem_wb_req), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
    .alu_wb_gnt(alu_wb_gnt), .mem_wb_gnt(mem_wb_gnt),
    .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .busy_count(busy_count), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [AW-1:0] rs, input logic rsu,
                           input logic [AW-1:0] rd, input logic rdw);
    issue_valid = v;
    issue_rs    = rs;
    rs_used     = rsu;
    issue_rd    = rd;
    rd_wr       = rdw;
  endtask

  // Monitor: every write the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset && rf_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rf_wr_addr", 32'(rf_wr_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("rf_wr_addr", 32'(rf_wr_addr), 32'(w.addr));
        chk("rf_wr_data", rf_wr_data, w.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  logic [AW-1:0] mem_a [2];
  logic [DW-1:0] mem_d [2];
  logic [AW-1:0] alu_a [2];
  logic [DW-1:0] alu_d [2];

  initial begin
    int mi;
    int ai;
    issue_valid = 0; issue_rs = 0; issue_rt = 0; rs_used = 0; rt_used = 0;
    issue_rd = 0; rd_wr = 0;
    alu_wb_req = 0; alu_wb_addr = 0; alu_wb_data = 0;
    mem_wb_req = 0; mem_wb_addr = 0; mem_wb_data = 0;

    // Reset state
    #12;
    chk("rst_rf_wr", 32'(rf_wr), 0);
    chk("rst_busy_count", 32'(busy_count), 0);
    chk("rst_wb_err", 32'(wb_err), 0);
    chk("rst_stall", 32'(issue_stall), 0);
    @(negedge clk); #2 reset = 1'b1;

    // ALU writeback r4 after issue sets busy[4]
    step(); set_issue(1, 0, 0, 4, 1);
    @(negedge clk); chk("t1_issue_stall", 32'(issue_stall), 0);
    step(); set_issue(0, 0, 0, 0, 0);
    alu_wb_req = 1; alu_wb_addr = 4; alu_wb_data = 32'h4; push(4, 32'h4);
    @(negedge clk);
    chk("t1_busy_count_n", 32'(busy_count), 1);
    chk("t1_alu_gnt", 32'(alu_wb_gnt), 1);
    chk("t1_mem_gnt", 32'(mem_wb_gnt), 0);
    step(); alu_wb_req = 0;
    @(negedge clk); chk("t1_busy_count_n1", 32'(busy_count), 1);
    step();
    @(negedge clk); chk("t1_busy_count_n2", 32'(busy_count), 0);

    // RAW hazard on r5: stall drops two cycles after the grant
    step(); set_issue(1, 0, 0, 5, 1);
    @(negedge clk); chk("t2_first_issue_stall", 32'(issue_stall), 0);
    step(); set_issue(1, 5, 1, 0, 0);
    alu_wb_req = 1; alu_wb_addr = 5; alu_wb_data = 32'h55; push(5, 32'h55);
    @(negedge clk);
    chk("t2_stall_n", 32'(issue_stall), 1);
    chk("t2_alu_gnt", 32'(alu_wb_gnt), 1);
    step(); alu_wb_req = 0;
    @(negedge clk); chk("t2_stall_n1", 32'(issue_stall), 1);
    step();
    @(negedge clk); chk("t2_stall_n2", 32'(issue_stall), 0);
    step(); set_issue(0, 0, 0, 0, 0);

    // Both requesters from reset: mem, alu, mem, alu
    reset = 1'b0; #2 reset = 1'b1;
    for (int r = 10; r < 14; r++) begin
      step(); set_issue(1, 0, 0, AW'(r), 1);
    end
    step(); set_issue(0, 0, 0, 0, 0);
    mem_a[0] = 10; mem_d[0] = 32'hA0A0; mem_a[1] = 12; mem_d[1] = 32'hC0C0;
    alu_a[0] = 11; alu_d[0] = 32'hB0B0; alu_a[1] = 13; alu_d[1] = 32'hD0D0;
    push(10, 32'hA0A0); push(11, 32'hB0B0); push(12, 32'hC0C0); push(13, 32'hD0D0);
    mi = 0; ai = 0;
    mem_wb_req = 1; mem_wb_addr = mem_a[0]; mem_wb_data = mem_d[0];
    alu_wb_req = 1; alu_wb_addr = alu_a[0]; alu_wb_data = alu_d[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t3_mem_gnt_%0d", k), 32'(mem_wb_gnt), 32'((k % 2) == 0));
      chk($sformatf("t3_alu_gnt_%0d", k), 32'(alu_wb_gnt), 32'((k % 2) == 1));
      step();
      if ((k % 2) == 0) begin
        mi++;
        if (mi < 2) begin mem_wb_addr = mem_a[mi]; mem_wb_data = mem_d[mi]; end
        else mem_wb_req = 0;
      end else begin
        ai++;
        if (ai < 2) begin alu_wb_addr = alu_a[ai]; alu_wb_data = alu_d[ai]; end
        else alu_wb_req = 0;
      end
    end
    step();
    @(negedge clk); chk("t3_busy_count_drained", 32'(busy_count), 0);
    chk("t3_wb_err", 32'(wb_err), 0);

    // r0: grant given, no write, no busy
    step(); set_issue(1, 0, 0, 0, 1);
    @(negedge clk); chk("t4_stall", 32'(issue_stall), 0);
    step(); set_issue(0, 0, 0, 0, 0);
    alu_wb_req = 1; alu_wb_addr = 0; alu_wb_data = 32'h1234;
    @(negedge clk);
    chk("t4_busy_count", 32'(busy_count), 0);
    chk("t4_alu_gnt", 32'(alu_wb_gnt), 1);
    step(); alu_wb_req = 0;
    @(negedge clk);
    chk("t4_rf_wr", 32'(rf_wr), 0);
    chk("t4_busy_count_after", 32'(busy_count), 0);
    chk("t4_wb_err", 32'(wb_err), 0);

    // Writeback to non-busy r7 sets sticky wb_err, write still happens
    step(); mem_wb_req = 1; mem_wb_addr = 7; mem_wb_data = 32'h77; push(7, 32'h77);
    @(negedge clk);
    chk("t5_mem_gnt", 32'(mem_wb_gnt), 1);
    chk("t5_wb_err_before", 32'(wb_err), 0);
    step(); mem_wb_req = 0;
    @(negedge clk); chk("t5_wb_err_set", 32'(wb_err), 1);
    step(); step();
    @(negedge clk); chk("t5_wb_err_sticky", 32'(wb_err), 1);

    // Reset mid-operation with three busy registers and a write in flight
    for (int r = 1; r < 4; r++) begin
      step(); set_issue(1, 0, 0, AW'(r), 1);
    end
    step(); set_issue(0, 0, 0, 0, 0);
    alu_wb_req = 1; alu_wb_addr = 2; alu_wb_data = 32'h22; push(2, 32'h22);
    mem_wb_req = 1; mem_wb_addr = 3; mem_wb_data = 32'h33;
    @(negedge clk);
    chk("t6_alu_gnt", 32'(alu_wb_gnt), 1);
    chk("t6_mem_gnt_wait", 32'(mem_wb_gnt), 0);
    step(); alu_wb_req = 0;
    @(negedge clk);
    chk("t6_busy_count_pre", 32'(busy_count), 3);
    chk("t6_rf_wr_pre", 32'(rf_wr), 1);
    #1 reset = 1'b0;
    set_issue(1, 1, 1, 0, 0);
    #1;
    chk("t6_rst_rf_wr", 32'(rf_wr), 0);
    chk("t6_rst_rf_wr_addr", 32'(rf_wr_addr), 0);
    chk("t6_rst_rf_wr_data", rf_wr_data, 0);
    chk("t6_rst_busy_count", 32'(busy_count), 0);
    chk("t6_rst_wb_err", 32'(wb_err), 0);
    chk("t6_rst_mem_gnt", 32'(mem_wb_gnt), 0);
    chk("t6_rst_stall", 32'(issue_stall), 0);
    set_issue(0, 0, 0, 0, 0);
    alu_wb_req = 1; alu_wb_addr = 2; alu_wb_data = 32'h222;
    push(3, 32'h33); push(2, 32'h222);
    #1 reset = 1'b1;
    #1;
    chk("t6_post_mem_gnt", 32'(mem_wb_gnt), 1);
    chk("t6_post_alu_gnt", 32'(alu_wb_gnt), 0);
    step(); mem_wb_req = 0;
    @(negedge clk); chk("t6_post_alu_gnt2", 32'(alu_wb_gnt), 1);
    step(); alu_wb_req = 0;
    step(); step();

    chk("exp_queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Write-port arbiter and hazard scoreboard for the decode-stage register file. Shares the file's single write port between the ALU and memory writeback paths using round-robin arbitration. Keeps one busy bit per architectural register and stalls decode on RAW/WAW hazards until the pending write has reached the register file. Sits between decode, the writeback stages and the register file write inputs.

## Interface
- NREG, 32, number of architectural registers
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs / issue_rt  in  AW  source register addresses
- rs_used / rt_used  in  1  source is actually read
- issue_rd  in  AW  destination register address
- rd_wr  in  1  instruction writes issue_rd
- issue_stall  out  1  decode must hold; combinational
- alu_wb_req / mem_wb_req  in  1  writeback request
- alu_wb_addr / mem_wb_addr  in  AW  writeback register
- alu_wb_data / mem_wb_data  in  DW  writeback data
- alu_wb_gnt / mem_wb_gnt  out  1  request accepted this cycle; combinational
- rf_wr  out  1  register file write enable; registered
- rf_wr_addr  out  AW  register file write address; registered
- rf_wr_data  out  DW  register file write data; registered
- busy_count  out  6  number of set busy bits; registered
- wb_err  out  1  sticky: writeback granted to a non-busy, nonzero register

## Operation
- busy[NREG-1:0]; busy[0] is hardwired to 0.
- Stall condition: issue_valid & ((rs_used & busy[rs]) | (rt_used & busy[rt]) | (rd_wr & busy[rd])).
- Accepted issue: issue_valid & !issue_stall. If rd_wr and rd≠0, set busy[rd] at the end of the cycle.
- Arbiter state is a 1-bit priority pointer with values PRI_MEM and PRI_ALU. Reset value is PRI_MEM.
  - Both requesters active: grant the prioritised one, then move the pointer to the other.
  - Single requester: grant it. The pointer then points away from the winner.
  - No request: pointer holds.
- Requester handshake: req, addr and data must stay stable until gnt. gnt is high for exactly the accepting cycle. A requester may re-request the following cycle.
- A granted write is registered into rf_wr/rf_wr_addr/rf_wr_data.
  - Address 0: gnt is still given, but rf_wr stays 0 and no busy bit is cleared.
- busy[rf_wr_addr] clears at the end of the cycle in which rf_wr=1. The register stays busy until the file holds the new value.
- Set and clear of the same register in the same cycle: the clear is applied first, then the set, so the result is busy=1.
- Grant to a nonzero register whose busy bit is 0 sets wb_err. The write still proceeds. wb_err clears only on reset.
- busy_count is a registered popcount of the next-state busy vector, range 0–31.

## Timing
- Reset (reset=0, asynchronous):
  - busy=0, rf_wr=0, rf_wr_addr=0, rf_wr_data=0, busy_count=0, wb_err=0, pointer=PRI_MEM.
  - Both gnt outputs are forced to 0; issue_stall=0.
- Reset mid-operation: pending busy bits and an in-flight rf_wr are discarded. Ungranted requests stay pending and compete normally after reset is released.
- Write latency: gnt in cycle N → rf_wr=1 in cycle N+1 → busy clear at end of N+1 → a dependent instruction's issue_stall drops in cycle N+2.
- Issue-to-stall: an issue accepted in cycle N sets busy at the end of N. A dependent instruction is stalled from cycle N+1.
- Throughput: one write per cycle. With both requesters continuously active, grants alternate every cycle.

## Test plan
- Reset, then ALU writeback r4 = 0x4 with busy[4] set by a prior issue → alu_wb_gnt in cycle N; rf_wr=1, addr=4, data=0x4 in N+1; busy_count goes 1→0.
- Issue rd=5, then next cycle issue rs=5 → issue_stall=1 until ALU writes r5. Stall drops exactly 2 cycles after the gnt.
- Both requesters active for 4 cycles from reset → gnt order mem, alu, mem, alu. The rf_wr_addr sequence matches.
- Issue rd=0 and writeback to r0 → busy_count stays 0, rf_wr stays 0, gnt still asserted.
- Writeback to r7 with busy[7]=0 → wb_err=1 and stays 1. r7 is written; wb_err returns to 0 only after reset.
- Assert reset with 3 busy registers and rf_wr high → all outputs 0 immediately. After release, a held mem request is granted first.
